// File: rtl/fifo_flags.sv
// fifo_flags: single-clock FIFO with occupancy count, almost-full/empty thresholds and sticky
// overflow/underflow flags. Define FIFO_FWFT_EN for first-word-fall-through reads.
module fifo_flags #(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wen,
    input  logic             ren,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int PW                 = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // When full, a simultaneous read frees the slot, so the write is still taken.
    assign rd_ok = ren && !empty;
    assign wr_ok = wen && (!full || ren);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            if (wr_ok && !rd_ok) begin
                count <= count + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count <= count - 1'b1;
            end
            // A fresh error event takes priority over a clear in the same cycle.
            if (wen && !wr_ok) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (ren && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    assign data_out   = mem[rd_ptr];
    assign data_valid = !empty;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= rd_ok;
            if (rd_ok) begin
                data_out <= mem[rd_ptr];
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_flags.sv
// Self-checking bench for fifo_flags: directed vector table, async-reset sequence and
// randomized traffic checked against a queue-based reference model.
module tb_fifo_flags;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wen = 1'b0;
    logic             ren = 1'b0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_out;
    logic             data_valid, full, empty, almost_full, almost_empty;
    logic [CW-1:0]    count;
    logic             overflow, underflow;

    fifo_flags #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren), .data_in(data_in),
        .clr_err(clr_err), .data_out(data_out), .data_valid(data_valid),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic             w, r, c;
        logic [WIDTH-1:0] d;
        int               cnt;
        logic [WIDTH-1:0] dout;
        logic             dv, ovf, unf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_flags(input int cnt);
        chk("count", 32'(count), 32'(cnt));
        chk("full", 32'(full), 32'(cnt == DEPTH));
        chk("empty", 32'(empty), 32'(cnt == 0));
        chk("almost_full", 32'(almost_full), 32'(cnt >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(cnt <= AE));
    endtask

    task automatic step(input logic w, input logic r, input logic c, input logic [WIDTH-1:0] d);
        wen = w; ren = r; clr_err = c; data_in = d;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic w, input logic r, input logic c,
                                input logic [WIDTH-1:0] d, input int cnt,
                                input logic [WIDTH-1:0] dout, input logic dv,
                                input logic ovf, input logic unf);
        vec_t v;
        v.w = w; v.r = r; v.c = c; v.d = d; v.cnt = cnt;
        v.dout = dout; v.dv = dv; v.ovf = ovf; v.unf = unf;
        tbl.push_back(v);
    endfunction

    task automatic do_reset();
        wen = 0; ren = 0; clr_err = 0;
        @(negedge clk);
        rst_n = 0;
        #2;
        rst_n = 1;
        @(negedge clk);
    endtask

    // Reference model state
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_dv, m_ovf, m_unf;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed table (registered-read build)
        for (int i = 1; i <= 8; i++) add(1, 0, 0, 8'(i), i, 8'h00, 0, 0, 0);
        add(1, 0, 0, 8'd66, 8, 8'h00, 0, 1, 0);
        for (int i = 1; i <= 8; i++) add(0, 1, 0, 8'h00, 8 - i, 8'(i), 1, 1, 0);
        add(0, 1, 0, 8'h00, 0, 8'd8, 0, 1, 1);
        add(0, 0, 1, 8'h00, 0, 8'd8, 0, 0, 0);
        for (int i = 1; i <= 8; i++) add(1, 0, 0, 8'(i), i, 8'd8, 0, 0, 0);
        add(1, 1, 0, 8'd9, 8, 8'd1, 1, 0, 0);
        for (int i = 2; i <= 9; i++) add(0, 1, 0, 8'h00, 9 - i, 8'(i), 1, 0, 0);
        add(1, 1, 0, 8'h5A, 1, 8'd9, 0, 0, 1);
        add(0, 1, 0, 8'h00, 0, 8'h5A, 1, 0, 1);
        add(0, 0, 1, 8'h00, 0, 8'h5A, 0, 0, 0);

        #12;
        chk_flags(0);
        chk("reset overflow", 32'(overflow), 0);
        chk("reset underflow", 32'(underflow), 0);
        chk("reset data_valid", 32'(data_valid), 32'(`ifdef FIFO_FWFT_EN 0 `else 0 `endif));
`ifndef FIFO_FWFT_EN
        chk("reset data_out", 32'(data_out), 0);
`endif
        rst_n = 1;
        @(negedge clk);

`ifndef FIFO_FWFT_EN
        foreach (tbl[i]) begin
            step(tbl[i].w, tbl[i].r, tbl[i].c, tbl[i].d);
            chk_flags(tbl[i].cnt);
            chk($sformatf("vec%0d data_out", i), 32'(data_out), 32'(tbl[i].dout));
            chk($sformatf("vec%0d data_valid", i), 32'(data_valid), 32'(tbl[i].dv));
            chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(tbl[i].ovf));
            chk($sformatf("vec%0d underflow", i), 32'(underflow), 32'(tbl[i].unf));
        end
`endif

        // Async reset with five words stored and underflow set
        do_reset();
        step(0, 1, 0, 8'h00);
        chk("pre-reset underflow", 32'(underflow), 1);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'h30 + i));
        wen = 0;
        chk("pre-reset count", 32'(count), 5);
        #2;
        rst_n = 0;
        #1;
        chk_flags(0);
        chk("async underflow", 32'(underflow), 0);
        chk("async overflow", 32'(overflow), 0);
        chk("async data_valid", 32'(data_valid), 0);
        @(negedge clk);
        rst_n = 1;
        step(1, 0, 0, 8'h11);
`ifdef FIFO_FWFT_EN
        chk("fwft data_out", 32'(data_out), 32'h11);
        chk("fwft data_valid", 32'(data_valid), 1);
`else
        chk("reg no-read data_valid", 32'(data_valid), 0);
        step(0, 1, 0, 8'h00);
        chk("reg data_out", 32'(data_out), 32'h11);
        chk("reg data_valid", 32'(data_valid), 1);
`endif

        // Randomized traffic against the queue model
        do_reset();
        q.delete();
        m_dout = '0; m_dv = 0; m_ovf = 0; m_unf = 0;
        for (int i = 0; i < 3000; i++) begin
            int pw;
            logic w, r, c, rd, wr, was_full, was_empty;
            logic [WIDTH-1:0] d;
            pw = (i / 300) % 3 == 0 ? 75 : ((i / 300) % 3 == 1 ? 50 : 25);
            w  = $urandom_range(0, 99) < pw;
            r  = $urandom_range(0, 99) < (100 - pw);
            c  = $urandom_range(0, 15) == 0;
            d  = 8'($urandom);
            was_full  = q.size() == DEPTH;
            was_empty = q.size() == 0;
            rd = r && !was_empty;
            wr = w && (!was_full || r);
            m_dv = rd;
            if (rd) m_dout = q.pop_front();
            if (wr) q.push_back(d);
            m_ovf = (w && !wr) ? 1'b1 : (c ? 1'b0 : m_ovf);
            m_unf = (r && was_empty) ? 1'b1 : (c ? 1'b0 : m_unf);
            step(w, r, c, d);
            chk_flags(q.size());
            chk("rand overflow", 32'(overflow), 32'(m_ovf));
            chk("rand underflow", 32'(underflow), 32'(m_unf));
`ifdef FIFO_FWFT_EN
            chk("rand data_valid", 32'(data_valid), 32'(q.size() != 0));
            if (q.size() != 0) chk("rand data_out", 32'(data_out), 32'(q[0]));
`else
            chk("rand data_valid", 32'(data_valid), 32'(m_dv));
            chk("rand data_out", 32'(data_out), 32'(m_dout));
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
